// File: rtl/mda_pkg.sv
// Shared constants for the MDA character path: cell width, attribute field
// masks, box-drawing code range and frame-counter bit positions.
package mda_pkg;

  localparam int CHAR_WIDTH_DEF = 9;
  localparam int BLINK_BITS_DEF = 5;

  localparam logic [2:0] FG_MASK = 3'b111;
  localparam logic [2:0] REV_BG  = 3'b111;
  localparam logic [2:0] UL_FG   = 3'b001;

  localparam logic [7:0] BOX_LO = 8'hC0;
  localparam logic [7:0] BOX_HI = 8'hDF;

  localparam int CUR_BIT = 3;
  localparam int CHR_BIT = 4;

  // Box-drawing glyphs replicate their rightmost font column into column 8.
  function automatic logic is_box(input logic [7:0] code);
    return (code >= BOX_LO) && (code <= BOX_HI);
  endfunction

endpackage

// File: rtl/mda_blink_counter.sv
// Frame counter advanced on every vsync rising edge; its upper bits pace the
// cursor flash (fast) and character blink (slow).
module mda_blink_counter
  import mda_pkg::*;
#(
  parameter int BLINK_BITS = BLINK_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync_in,
  output logic cur_on,
  output logic blink_on
);

  logic [BLINK_BITS-1:0] cnt;
  logic                  vsync_d;

  // Edge detect runs every clk so a vsync pulse is never missed between pix_ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync_in;
      if (vsync_in && !vsync_d) cnt <= cnt + 1'b1;
    end
  end

  assign cur_on   = cnt[CUR_BIT];
  assign blink_on = cnt[CHR_BIT];

endmodule

// File: rtl/mda_char_serializer.sv
// Serializes one MDA character cell per char_load into CHAR_WIDTH pixels and
// applies the attribute rules; two pix_ce stages keep sync/de pixel-aligned.
module mda_char_serializer
  import mda_pkg::*;
#(
  parameter int CHAR_WIDTH = CHAR_WIDTH_DEF,
  parameter int BLINK_BITS = BLINK_BITS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       char_load,
  input  logic [7:0] font_row,
  input  logic [7:0] char_code,
  input  logic [7:0] attr,
  input  logic       cursor_in,
  input  logic       ul_row,
  input  logic       blink_enable,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  output logic       video,
  output logic       intensity,
  output logic       hsync,
  output logic       vsync,
  output logic       display_enable
);

  localparam int              COL_W    = $clog2(CHAR_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHAR_WIDTH - 1);

  logic                  cur_on;
  logic                  blink_on;

  logic [CHAR_WIDTH-1:0] shreg_p0;
  logic [COL_W-1:0]      col_p0;
  logic                  live_p0;
  logic                  hsync_p0;
  logic                  vsync_p0;
  logic                  de_p0;
  logic [7:0]            attr_p0;
  logic                  cursor_p0;
  logic                  ul_p0;
  logic                  cur_on_p0;
  logic                  blink_on_p0;

  logic [CHAR_WIDTH-1:0] load_val;
  logic                  video_c;
  logic                  intensity_c;

  mda_blink_counter #(
    .BLINK_BITS(BLINK_BITS)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .vsync_in(vsync_in),
    .cur_on  (cur_on),
    .blink_on(blink_on)
  );

  function automatic logic cell_video(
    input logic       p,
    input logic [7:0] a,
    input logic       ul,
    input logic       cursor,
    input logic       cur_flash,
    input logic       blink_phase,
    input logic       blink_en
  );
    logic fg;
    logic blank;
    logic rev;
    logic v;
    blank = ((a[2:0] & FG_MASK) == 3'b000) && (a[6:4] != REV_BG);
    rev   = (a[6:4] == REV_BG) && ((a[2:0] & FG_MASK) == 3'b000);
    if (blank)    fg = 1'b0;
    else if (rev) fg = p;
    else          fg = p | (((a[2:0] & FG_MASK) == UL_FG) & ul);
    if (blink_en && a[7] && !blink_phase) fg = 1'b0;
    v = rev ? ~fg : fg;
    if (cursor && cur_flash) v = 1'b1;
    return v;
  endfunction

  always_comb begin
    load_val                 = '0;
    load_val[CHAR_WIDTH-1 -: 8] = font_row;
    load_val[CHAR_WIDTH-9]   = is_box(char_code) & font_row[0];
  end

  // Stage 1: cell capture / shift and timing capture
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_p0 <= '0;
      col_p0   <= '0;
      live_p0  <= 1'b0;
      hsync_p0 <= 1'b0;
      vsync_p0 <= 1'b0;
      de_p0    <= 1'b0;
    end else if (pix_ce) begin
      hsync_p0 <= hsync_in;
      vsync_p0 <= vsync_in;
      de_p0    <= de_in;
      if (char_load) begin
        shreg_p0 <= load_val;
        col_p0   <= '0;
        live_p0  <= 1'b1;
      end else begin
        shreg_p0 <= {shreg_p0[CHAR_WIDTH-2:0], 1'b0};
        if (col_p0 == COL_LAST) live_p0 <= 1'b0;
        else                    col_p0  <= col_p0 + 1'b1;
      end
    end
  end

  // Counter phase is captured at load so a coincident vsync edge takes effect next cell.
  always_ff @(posedge clk) begin
    if (pix_ce && char_load) begin
      attr_p0     <= attr;
      cursor_p0   <= cursor_in;
      ul_p0       <= ul_row;
      cur_on_p0   <= cur_on;
      blink_on_p0 <= blink_on;
    end
  end

  always_comb begin
    video_c     = de_p0 & live_p0 &
                  cell_video(shreg_p0[CHAR_WIDTH-1], attr_p0, ul_p0, cursor_p0,
                             cur_on_p0, blink_on_p0, blink_enable);
    intensity_c = video_c & attr_p0[3];
  end

  // Stage 2: registered pixel and timing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      video          <= 1'b0;
      intensity      <= 1'b0;
      hsync          <= 1'b0;
      vsync          <= 1'b0;
      display_enable <= 1'b0;
    end else if (pix_ce) begin
      video          <= video_c;
      intensity      <= intensity_c;
      hsync          <= hsync_p0;
      vsync          <= vsync_p0;
      display_enable <= de_p0;
    end
  end

endmodule

// File: tb/tb_mda_char_serializer.sv
// Directed bench for mda_char_serializer: glyph, box, attribute, blink, cursor,
// reset and pix_ce-gating cases with hand-computed expectations.
module tb_mda_char_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic       char_load;
  logic [7:0] font_row;
  logic [7:0] char_code;
  logic [7:0] attr;
  logic       cursor_in;
  logic       ul_row;
  logic       blink_enable;
  logic       hsync_in;
  logic       vsync_in;
  logic       de_in;
  logic       video;
  logic       intensity;
  logic       hsync;
  logic       vsync;
  logic       display_enable;

  int checks   = 0;
  int failures = 0;

  mda_char_serializer dut (
    .clk           (clk),
    .reset         (reset),
    .pix_ce        (pix_ce),
    .char_load     (char_load),
    .font_row      (font_row),
    .char_code     (char_code),
    .attr          (attr),
    .cursor_in     (cursor_in),
    .ul_row        (ul_row),
    .blink_enable  (blink_enable),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .de_in         (de_in),
    .video         (video),
    .intensity     (intensity),
    .hsync         (hsync),
    .vsync         (vsync),
    .display_enable(display_enable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic load_cell(input logic [7:0] f, input logic [7:0] c,
                           input logic [7:0] a, input logic cur, input logic ul);
    font_row  = f;
    char_code = c;
    attr      = a;
    cursor_in = cur;
    ul_row    = ul;
    char_load = 1'b1;
    tick();
    char_load = 1'b0;
  endtask

  task automatic expect_cell(input string tag, input logic [8:0] ev, input logic [8:0] ei);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("%s video col%0d", tag, k), video, ev[8-k]);
      chk($sformatf("%s intensity col%0d", tag, k), intensity, ei[8-k]);
    end
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    pix_ce       = 1'b0;
    char_load    = 1'b0;
    font_row     = 8'h00;
    char_code    = 8'h00;
    attr         = 8'h00;
    cursor_in    = 1'b0;
    ul_row       = 1'b0;
    blink_enable = 1'b1;
    hsync_in     = 1'b0;
    vsync_in     = 1'b0;
    de_in        = 1'b0;
    repeat (3) tick();
    chk("reset video", video, 1'b0);
    chk("reset intensity", intensity, 1'b0);
    chk("reset hsync", hsync, 1'b0);
    chk("reset vsync", vsync, 1'b0);
    chk("reset de", display_enable, 1'b0);

    reset  = 1'b0;
    pix_ce = 1'b1;
    de_in  = 1'b1;
    repeat (2) tick();

    // Plain glyph
    load_cell(8'hA5, 8'h41, 8'h07, 1'b0, 1'b0);
    expect_cell("glyphA", 9'b101001010, 9'b000000000);
    chk("glyphA de", display_enable, 1'b1);

    // Box-drawing extension versus ordinary character
    load_cell(8'hFF, 8'hC4, 8'h0F, 1'b0, 1'b0);
    expect_cell("box", 9'h1FF, 9'h1FF);
    load_cell(8'hFF, 8'h41, 8'h0F, 1'b0, 1'b0);
    expect_cell("nobox", 9'b111111110, 9'b111111110);

    // Attribute rules
    load_cell(8'h00, 8'h41, 8'h70, 1'b0, 1'b0);
    expect_cell("reverse", 9'h1FF, 9'h000);
    load_cell(8'h00, 8'h41, 8'h01, 1'b0, 1'b1);
    expect_cell("underline", 9'h1FF, 9'h000);
    load_cell(8'hFF, 8'h41, 8'h00, 1'b0, 1'b0);
    expect_cell("blank", 9'h000, 9'h000);

    // Blink across a full counter period
    for (int f = 0; f < 32; f++) begin
      load_cell(8'hFF, 8'h41, 8'h87, 1'b0, 1'b0);
      tick();
      chk($sformatf("blink frame%0d", f), video, (f >= 16) ? 1'b1 : 1'b0);
      vsync_pulse();
    end
    blink_enable = 1'b0;
    load_cell(8'hFF, 8'h41, 8'h87, 1'b0, 1'b0);
    tick();
    chk("blink disabled", video, 1'b1);
    blink_enable = 1'b1;

    // Cursor, counter now 0
    load_cell(8'h00, 8'h41, 8'h07, 1'b1, 1'b0);
    expect_cell("cursor off", 9'h000, 9'h000);
    repeat (7) vsync_pulse();
    vsync_in = 1'b1;
    load_cell(8'h00, 8'h41, 8'h07, 1'b1, 1'b0);
    vsync_in = 1'b0;
    tick();
    chk("cursor coincident edge", video, 1'b0);
    load_cell(8'h00, 8'h41, 8'h07, 1'b1, 1'b0);
    expect_cell("cursor on", 9'h1FF, 9'h000);
    tick();
    chk("cursor after cell", video, 1'b0);

    // Reset in mid-cell
    load_cell(8'h00, 8'h41, 8'h0F, 1'b1, 1'b0);
    tick();
    chk("pre-reset video", video, 1'b1);
    chk("pre-reset de", display_enable, 1'b1);
    reset = 1'b1;
    tick();
    chk("midreset video", video, 1'b0);
    chk("midreset intensity", intensity, 1'b0);
    chk("midreset de", display_enable, 1'b0);
    chk("midreset hsync", hsync, 1'b0);
    chk("midreset vsync", vsync, 1'b0);
    reset = 1'b0;
    repeat (2) tick();
    chk("no load after reset", video, 1'b0);
    repeat (7) vsync_pulse();
    load_cell(8'h00, 8'h41, 8'h07, 1'b1, 1'b0);
    tick();
    chk("counter cleared 7", video, 1'b0);
    vsync_pulse();
    load_cell(8'h00, 8'h41, 8'h07, 1'b1, 1'b0);
    tick();
    chk("counter cleared 8", video, 1'b1);

    // pix_ce every second clock
    cursor_in = 1'b0;
    repeat (10) tick();
    chk("ce idle", video, 1'b0);
    load_cell(8'hA5, 8'h41, 8'h07, 1'b0, 1'b0);
    chk("ce load event", video, 1'b0);
    pix_ce = 1'b0;
    tick();
    chk("ce hold before col0", video, 1'b0);
    pix_ce = 1'b1;
    tick();
    chk("ce col0", video, 1'b1);
    pix_ce = 1'b0;
    tick();
    chk("ce hold col0", video, 1'b1);
    pix_ce = 1'b1;
    tick();
    chk("ce col1", video, 1'b0);

    pix_ce   = 1'b1;
    hsync_in = 1'b1;
    tick();
    chk("hsync event m", hsync, 1'b0);
    pix_ce   = 1'b0;
    hsync_in = 1'b0;
    tick();
    chk("hsync idle", hsync, 1'b0);
    pix_ce = 1'b1;
    tick();
    chk("hsync event m+1", hsync, 1'b1);
    pix_ce = 1'b0;
    tick();
    chk("hsync hold", hsync, 1'b1);
    pix_ce = 1'b1;
    tick();
    chk("hsync event m+2", hsync, 1'b0);

    de_in = 1'b0;
    tick();
    chk("de event m", display_enable, 1'b1);
    pix_ce = 1'b0;
    de_in  = 1'b1;
    tick();
    pix_ce = 1'b1;
    tick();
    chk("de event m+1", display_enable, 1'b0);
    pix_ce = 1'b0;
    tick();
    pix_ce = 1'b1;
    tick();
    chk("de event m+2", display_enable, 1'b1);

    // Display disabled suppresses pixels
    de_in = 1'b0;
    load_cell(8'hFF, 8'h41, 8'h0F, 1'b0, 1'b0);
    tick();
    chk("de off video", video, 1'b0);
    chk("de off intensity", intensity, 1'b0);
    chk("de off output", display_enable, 1'b0);
    tick();
    chk("de off video col1", video, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mda_char_serializer.md
Name: mda_char_serializer

Overview:
- Upstream neighbour of the MDA HDMI output stage.
- Per character cell it takes the font row, character code, attribute byte and cursor flag from the CRTC/fetch logic. It serializes them into a 9-pixel-wide cell and applies MDA attribute rules: blank, normal, reverse, underline, intensity, blink and cursor.
- Outputs are pixel-aligned video, intensity, hsync, vsync and display_enable, which drive the HDMI port stage directly.

Parameters:
- CHAR_WIDTH, 9, pixels per character cell (columns 0..CHAR_WIDTH-1).
- BLINK_BITS, 5, width of the frame counter used for blink timing.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock enable; every state update is qualified by it unless stated otherwise
- char_load  in  1  with pix_ce: first pixel of a new cell; font_row/char_code/attr/cursor_in/ul_row valid this cycle
- font_row  in  8  glyph row bits, bit7 = leftmost pixel
- char_code  in  8  character code, used for 9th-column extension
- attr  in  8  MDA attribute byte
- cursor_in  in  1  cell is the cursor position and the current scanline is within the cursor rows
- ul_row  in  1  current scanline is the underline row
- blink_enable  in  1  1: attr[7] = blink; 0: attr[7] ignored
- hsync_in, vsync_in, de_in  in  1 each  CRTC timing, pixel-aligned with char_load
- video  out  1  pixel on/off
- intensity  out  1  high-intensity pixel
- hsync, vsync, display_enable  out  1 each  delayed timing, aligned with video

Behaviour:
- Reset: video, intensity, hsync, vsync, display_enable = 0; shift register, column counter and frame counter = 0.
- Pipeline: two pix_ce stages.
  - Stage 1 captures the cell and the timing.
  - Stage 2 registers the outputs.
  - Inputs sampled at pix_ce event n appear on the outputs after event n+1.
  - Column k of a cell loaded at event n appears after event n+1+k.
  - hsync/vsync/de pass through exactly two registers so they stay aligned with pixels.
- No pix_ce: all registers hold.
- Load (char_load & pix_ce):
  - shreg <= {font_row, col8}.
  - col8 = font_row[0] when char_code is 0xC0..0xDF, else 0.
  - attr, cursor_in and ul_row are latched for the cell; the column counter is set to 0.
- Shift (pix_ce, no char_load):
  - shreg shifts left and fills with 0.
  - The column counter saturates at CHAR_WIDTH-1.
  - A late or missing char_load therefore yields blank pixels, never stale glyph data.
- char_load mid-cell: reload immediately; the remainder of the old cell is discarded.
- Frame counter: BLINK_BITS-bit counter, +1 on each vsync_in rising edge (edge detected on clk, independent of pix_ce), wrapping 31→0.
  - cur_on = cnt[3].
  - blink_on = cnt[4].
- Pixel function at stage 2 (p = shreg MSB; a = latched attr):
  - blank when a[2:0]==0 and a[6:4]!=7 → fg = 0.
  - reverse when a[6:4]==7 and a[2:0]==0.
  - else normal: fg = p, or 1 when a[2:0]==1 and ul_row (underline spans all 9 columns).
  - blink: if blink_enable & a[7] & !blink_on → fg = 0 (applied before reverse).
  - video = reverse ? ~fg : fg.
  - cursor: if latched cursor & cur_on → video = 1 for the whole cell.
  - intensity = video & a[3].
  - de stage-1 value 0 → video = 0, intensity = 0.
- Simultaneous vsync edge and char_load: the cell uses the pre-increment counter value for that load; the counter updates in the same cycle.
- Reset mid-cell: outputs 0 on the next clk; the first cell after reset requires a char_load.

Decomposition:
- Package mda_pkg:
  - CHAR_WIDTH default.
  - Attribute masks: FG_MASK 3'b111, REV_BG 3'b111, UL_FG 3'b001.
  - Box-drawing range constants BOX_LO 8'hC0, BOX_HI 8'hDF.
  - Blink bit indices CUR_BIT 3, CHR_BIT 4.
- Sub-module mda_blink_counter: vsync edge detect plus frame counter, exporting cur_on and blink_on.

Test Plan:
- Glyph A, attr 0x07, font_row 0xA5, char_code 0x41, pix_ce every cycle, de=1 → video columns 0..8 = 1,0,1,0,0,1,0,1,0; intensity 0; first pixel two cycles after load.
- Box char, char_code 0xC4, font_row 0xFF, attr 0x0F → 9 columns video=1, intensity=1. Same with char_code 0x41 → column 8 = 0.
- Attributes with font_row 0x00: attr 0x70 → video=1 all columns. Attr 0x01 with ul_row=1 → 9 columns video=1. Attr 0x00 with font_row 0xFF → all 0.
- Blink, attr 0x87, font_row 0xFF, blink_enable=1, 32 vsync pulses → video 0 for frames 0-15 and 1 for frames 16-31. With blink_enable=0 → always 1.
- Cursor, cursor_in=1, font_row 0x00, attr 0x07 → video=1 for 9 columns only when frame count[3]=1. Reset asserted mid-cell → all outputs 0 next clk, counter back to 0.
- pix_ce asserted every 2nd clk: outputs change only after pix_ce events, de_in/hsync_in pulses emerge exactly 2 pix_ce events later. de_in=0 with font 0xFF → video=0.
